// File: rtl/conv_maxpool2x2.sv
// Streaming 2x2 stride-1 max-pool over raster-ordered feature maps.
// One previous-row line buffer plus left/diag taps form the window; output is registered.
module conv_maxpool2x2 #(
  parameter int DATA_W = 8,
  parameter int MAP_W  = 5,
  parameter int MAP_H  = 5,
  parameter int N_MAP  = 6
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int COL_W = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int ROW_W = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int MAP_CW = (N_MAP > 1) ? $clog2(N_MAP) : 1;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(MAP_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(MAP_H - 1);
  localparam logic [MAP_CW-1:0] MAP_LAST = MAP_CW'(N_MAP - 1);

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [MAP_CW-1:0] r_map;
  logic [DATA_W-1:0] r_line [MAP_W];
  logic [DATA_W-1:0] r_left;
  logic [DATA_W-1:0] r_diag;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;

  logic              w_col_end;
  logic              w_row_end;
  logic              w_map_end;
  logic              w_emit;
  logic              w_frame_end;
  logic [DATA_W-1:0] w_line_col;
  logic [DATA_W-1:0] w_max;

  function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign w_col_end   = (r_col == COL_LAST);
  assign w_row_end   = (r_row == ROW_LAST);
  assign w_map_end   = (r_map == MAP_LAST);
  assign w_frame_end = w_col_end & w_row_end & w_map_end;
  // Row 0 and column 0 lack a full window; stale line/left/diag contents are never emitted.
  assign w_emit      = in_valid & (r_row != {ROW_W{1'b0}}) & (r_col != {COL_W{1'b0}});
  assign w_line_col  = r_line[r_col];
  assign w_max       = max2(max2(r_diag, w_line_col), max2(r_left, in_data));

  // Raster position counters, advanced only on accepted beats.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= {COL_W{1'b0}};
      r_row <= {ROW_W{1'b0}};
      r_map <= {MAP_CW{1'b0}};
    end else if (in_valid) begin
      if (w_col_end) begin
        r_col <= {COL_W{1'b0}};
        if (w_row_end) begin
          r_row <= {ROW_W{1'b0}};
          r_map <= w_map_end ? {MAP_CW{1'b0}} : r_map + MAP_CW'(1);
        end else begin
          r_row <= r_row + ROW_W'(1);
        end
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Window storage: previous row, previous pixel and the old line entry one column back.
  always_ff @(posedge clk1) begin
    if (in_valid) begin
      r_diag         <= w_line_col;
      r_line[r_col]  <= in_data;
      r_left         <= in_data;
    end
  end

  // Registered output stage; data is zeroed on non-emitting cycles.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {DATA_W{1'b0}};
      r_out_last  <= 1'b0;
    end else begin
      r_out_valid <= w_emit;
      r_out_data  <= w_emit ? w_max : {DATA_W{1'b0}};
      r_out_last  <= w_emit & w_frame_end;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_conv_maxpool2x2.sv
// Self-checking bench for conv_maxpool2x2: a window-max model over a pixel array
// checks every cycle, and literal expectations pin the model on directed frames.
module tb_conv_maxpool2x2;

  logic       clk1 = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;

  int checks = 0;
  int errors = 0;

  conv_maxpool2x2 #(.DATA_W(8), .MAP_W(5), .MAP_H(5), .N_MAP(6)) dut (
    .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Model: beat index within the frame gives (map,row,col); window max from stored pixels.
  int   bidx = 0;
  int   px [5][5];
  logic m_ev = 1'b0;
  int   m_ed = 0;
  logic m_el = 1'b0;

  always @(posedge clk1) begin
    int r, c;
    if (!rst_n) begin
      bidx = 0;
      m_ev = 1'b0; m_ed = 0; m_el = 1'b0;
    end else if (in_valid) begin
      r = (bidx % 25) / 5;
      c = bidx % 5;
      px[r][c] = int'(in_data);
      if (r >= 1 && c >= 1) begin
        m_ev = 1'b1;
        m_ed = max4(px[r-1][c-1], px[r-1][c], px[r][c-1], px[r][c]);
        m_el = (bidx == 149);
      end else begin
        m_ev = 1'b0; m_ed = 0; m_el = 1'b0;
      end
      bidx = (bidx + 1) % 150;
    end else begin
      m_ev = 1'b0; m_ed = 0; m_el = 1'b0;
    end
    #1;
    chk("cyc_valid", {31'd0, out_valid}, {31'd0, m_ev});
    if (m_ev) begin
      chk("cyc_data", {24'd0, out_data}, m_ed);
      chk("cyc_last", {31'd0, out_last}, {31'd0, m_el});
    end else begin
      chk("idle_data", {24'd0, out_data}, 32'd0);
      chk("idle_last", {31'd0, out_last}, 32'd0);
    end
  end

  // Output log for the directed literal checks.
  int   got_q[$];
  int   nlast = 0;
  time  first_t = 0;
  logic seen = 1'b0;

  always @(negedge clk1) begin
    if (out_valid) begin
      got_q.push_back(int'(out_data));
      if (out_last) nlast++;
      if (!seen) begin
        first_t = $time;
        seen = 1'b1;
      end
    end
  end

  time t6 = 0;

  task automatic beat(input int d);
    @(negedge clk1);
    in_valid = 1'b1;
    in_data  = 8'(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk1);
      in_valid = 1'b0;
      in_data  = 8'($urandom_range(255, 0));
    end
  endtask

  task automatic clear_log();
    got_q.delete();
    nlast = 0;
    seen = 1'b0;
  endtask

  task automatic ramp(input int max_gap);
    for (int b = 0; b < 150; b++) begin
      beat(b);
      if (b == 6) t6 = $time;
      if (max_gap > 0) idle($urandom_range(max_gap, 0));
    end
  endtask

  task automatic check_ramp(input string name, input int n);
    chk({name, "_count"}, got_q.size(), n);
    for (int k = 0; k < n && k < got_q.size(); k++) begin
      int kk, m, i, j;
      kk = k % 96;
      m = kk / 16; i = (kk % 16) / 4; j = kk % 4;
      chk(name, got_q[k], 25 * m + 5 * (i + 1) + (j + 1));
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    idle(2);
    @(negedge clk1) rst_n = 1'b1;
    idle(3);
    @(negedge clk1) rst_n = 1'b0;
    idle(2);
    @(negedge clk1) rst_n = 1'b1;
    idle(2);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_data", {24'd0, out_data}, 32'd0);

    // Ramp frame, no gaps
    clear_log();
    ramp(0);
    idle(3);
    chk("ramp_first", got_q.size() > 0 ? got_q[0] : -1, 6);
    chk("ramp_16th", got_q.size() > 15 ? got_q[15] : -1, 24);
    chk("ramp_96th", got_q.size() > 95 ? got_q[95] : -1, 149);
    chk("ramp_nlast", nlast, 1);
    chk("ramp_latency", 32'(first_t - t6), 32'd10);
    check_ramp("ramp", 96);

    // Single 200 at (2,2) in map 0
    clear_log();
    for (int b = 0; b < 150; b++) beat(b == 12 ? 200 : 0);
    idle(3);
    chk("peak_count", got_q.size(), 96);
    for (int k = 0; k < 16 && k < got_q.size(); k++)
      chk("peak_map0", got_q[k], (k == 5 || k == 6 || k == 9 || k == 10) ? 200 : 0);

    // 255 at corners (0,0) and (4,4) of map 0
    clear_log();
    for (int b = 0; b < 150; b++) beat((b == 0 || b == 24) ? 255 : 0);
    idle(3);
    chk("corner_count", got_q.size(), 96);
    for (int k = 0; k < 16 && k < got_q.size(); k++)
      chk("corner_map0", got_q[k], (k == 0 || k == 15) ? 255 : 0);

    // Gapped ramp
    clear_log();
    ramp(3);
    idle(3);
    check_ramp("gap", 96);
    chk("gap_nlast", nlast, 1);

    // Back-to-back frames
    clear_log();
    ramp(0);
    ramp(0);
    idle(3);
    check_ramp("b2b", 192);
    chk("b2b_nlast", nlast, 2);
    chk("b2b_second_first", got_q.size() > 96 ? got_q[96] : -1, 6);

    // Mid-frame reset after 40 beats
    for (int b = 0; b < 40; b++) beat(b);
    @(negedge clk1);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_data", {24'd0, out_data}, 32'd39);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("async_valid", {31'd0, out_valid}, 32'd0);
    chk("async_data", {24'd0, out_data}, 32'd0);
    idle(2);
    @(negedge clk1) rst_n = 1'b1;
    idle(2);
    clear_log();
    ramp(0);
    idle(3);
    check_ramp("after_rst", 96);
    chk("after_rst_nlast", nlast, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
